// File: rtl/box_collision_reader.sv
// Scans a BOX_W x BOX_H framebuffer region row-major and counts pixels that differ
// from a latched background colour, tolerating a fixed framebuffer read latency.
module box_collision_reader #(
    parameter int BOX_W  = 4,
    parameter int BOX_H  = 4,
    parameter int X_MAX  = 159,
    parameter int Y_MAX  = 119,
    parameter int RD_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] x_in,
    input  logic [6:0] y_in,
    input  logic [2:0] bg_colour,
    output logic       rd_en,
    output logic [7:0] rd_x,
    output logic [6:0] rd_y,
    input  logic [2:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       hit,
    output logic [6:0] hit_count
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [2:0] CX_LAST    = 3'(BOX_W - 1);
    localparam logic [2:0] CY_LAST    = 3'(BOX_H - 1);
    localparam logic [1:0] DRAIN_LAST = 2'(RD_LAT - 1);

    state_t            state;
    logic [2:0]        cx, cy;
    logic [2:0]        nxt_cx, nxt_cy;
    logic [1:0]        drain_cnt;
    logic [7:0]        x_q;
    logic [6:0]        y_q;
    logic [2:0]        bg_q;
    logic [RD_LAT-1:0] vld;
    logic [8:0]        sum_x;
    logic [7:0]        sum_y;
    logic              last_pix;
    logic              data_hit;

    // Bounds are checked on the widened sums so a box hanging off the right or
    // bottom edge never wraps back onto the screen.
    function automatic logic on_screen(input logic [8:0] sx, input logic [7:0] sy);
        return (sx <= 9'(X_MAX)) && (sy <= 8'(Y_MAX));
    endfunction

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        nxt_cx = cx + 3'd1;
        nxt_cy = cy;
        if (cx == CX_LAST) begin
            nxt_cx = '0;
            nxt_cy = cy + 3'd1;
        end
    end

    assign sum_x    = {1'b0, x_q} + {6'd0, nxt_cx};
    assign sum_y    = {1'b0, y_q} + {5'd0, nxt_cy};
    assign last_pix = (cx == CX_LAST) && (cy == CY_LAST);
    assign data_hit = vld[RD_LAT-1] && (rd_data != bg_q);

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the valid pipeline is cleared too, otherwise reads in flight at reset would still be counted.
            state     <= IDLE;
            cx        <= '0;
            cy        <= '0;
            drain_cnt <= '0;
            x_q       <= '0;
            y_q       <= '0;
            bg_q      <= '0;
            vld       <= '0;
            rd_en     <= 1'b0;
            rd_x      <= '0;
            rd_y      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hit       <= 1'b0;
            hit_count <= '0;
        end else begin
            vld <= (vld << 1) | RD_LAT'(rd_en);
            if (data_hit) begin
                hit       <= 1'b1;
                hit_count <= hit_count + 7'd1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        x_q       <= x_in;
                        y_q       <= y_in;
                        bg_q      <= bg_colour;
                        cx        <= '0;
                        cy        <= '0;
                        hit       <= 1'b0;
                        hit_count <= '0;
                        busy      <= 1'b1;
                        rd_en     <= on_screen({1'b0, x_in}, {1'b0, y_in});
                        rd_x      <= x_in;
                        rd_y      <= y_in;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (last_pix) begin
                        rd_en     <= 1'b0;
                        rd_x      <= '0;
                        rd_y      <= '0;
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end else begin
                        cx    <= nxt_cx;
                        cy    <= nxt_cy;
                        rd_en <= on_screen(sum_x, sum_y);
                        rd_x  <= sum_x[7:0];
                        rd_y  <= sum_y[6:0];
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_box_collision_reader.sv
// Bench for box_collision_reader: two instances (RD_LAT=1 and RD_LAT=3) share stimulus and a
// modelled framebuffer; each scan is compared against a pixel-level reference of the box.
module tb_box_collision_reader;

    localparam int N    = 16;
    localparam int MAXC = 24;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] x_in;
    logic [6:0] y_in;
    logic [2:0] bg_colour;

    logic       rd_en1, busy1, done1, hit1;
    logic [7:0] rd_x1;
    logic [6:0] rd_y1, hit_count1;
    logic [2:0] rd_data1;
    logic       rd_en3, busy3, done3, hit3;
    logic [7:0] rd_x3;
    logic [6:0] rd_y3, hit_count3;
    logic [2:0] rd_data3;

    logic [2:0] fb [0:159][0:119];
    logic [2:0] pipe1;
    logic [2:0] pipe3 [0:2];

    logic       en_r1   [0:MAXC];
    logic       en_r3   [0:MAXC];
    logic       busy_r1 [0:MAXC];
    logic [7:0] x_r1    [0:MAXC];
    logic [7:0] x_r3    [0:MAXC];
    logic [6:0] y_r1    [0:MAXC];
    logic [6:0] y_r3    [0:MAXC];
    int         done_c1, done_c3, done_n1, done_n3;
    logic       hit_d1, hit_d3;
    logic [6:0] cnt_d1, cnt_d3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    box_collision_reader #(.RD_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .x_in(x_in), .y_in(y_in),
        .bg_colour(bg_colour), .rd_en(rd_en1), .rd_x(rd_x1), .rd_y(rd_y1),
        .rd_data(rd_data1), .busy(busy1), .done(done1), .hit(hit1), .hit_count(hit_count1)
    );

    box_collision_reader #(.RD_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .start(start), .x_in(x_in), .y_in(y_in),
        .bg_colour(bg_colour), .rd_en(rd_en3), .rd_x(rd_x3), .rd_y(rd_y3),
        .rd_data(rd_data3), .busy(busy3), .done(done3), .hit(hit3), .hit_count(hit_count3)
    );

    function automatic logic [2:0] fb_read(input logic [7:0] x, input logic [6:0] y);
        if (x <= 8'd159 && y <= 7'd119) return fb[x][y];
        return 3'bxxx;
    endfunction

    // Framebuffer read ports: garbage on rd_data whenever no read was issued.
    always @(posedge clk) begin
        pipe1    <= rd_en1 ? fb_read(rd_x1, rd_y1) : 3'($urandom);
        pipe3[0] <= rd_en3 ? fb_read(rd_x3, rd_y3) : 3'($urandom);
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign rd_data1 = pipe1;
    assign rd_data3 = pipe3[2];

    function automatic int model_count(input int x, input int y, input int bg);
        int n = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (x + c <= 159 && y + r <= 119 && fb[x + c][y + r] != 3'(bg)) n++;
        return n;
    endfunction

    task automatic fill_box(input int x, input int y, input int colour);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (x + c <= 159 && y + r <= 119) fb[x + c][y + r] = 3'(colour);
    endtask

    task automatic clear_fb();
        for (int i = 0; i < 160; i++)
            for (int j = 0; j < 120; j++) fb[i][j] = 3'd0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // One scan on both instances; hold keeps start=1 and moves x_in to 10 after acceptance.
    task automatic run_scan(input int x, input int y, input int bg, input bit hold);
        int exp_cnt;
        exp_cnt = model_count(x, y, bg);
        @(posedge clk); #1;
        start = 1'b1; x_in = 8'(x); y_in = 7'(y); bg_colour = 3'(bg);
        @(posedge clk); #1;
        if (hold) x_in = 8'd10;
        else start = 1'b0;
        y_in      = 7'($urandom);
        bg_colour = 3'($urandom);
        done_c1 = 0; done_c3 = 0; done_n1 = 0; done_n3 = 0;
        for (int c = 1; c <= MAXC; c++) begin
            @(negedge clk);
            en_r1[c] = rd_en1; x_r1[c] = rd_x1; y_r1[c] = rd_y1; busy_r1[c] = busy1;
            en_r3[c] = rd_en3; x_r3[c] = rd_x3; y_r3[c] = rd_y3;
            if (done1 === 1'b1) begin
                done_n1++;
                if (done_c1 == 0) begin done_c1 = c; hit_d1 = hit1; cnt_d1 = hit_count1; end
            end
            if (done3 === 1'b1) begin
                done_n3++;
                if (done_c3 == 0) begin done_c3 = c; hit_d3 = hit3; cnt_d3 = hit_count3; end
            end
        end
        for (int c = 1; c <= N; c++) begin
            int  cx = (c - 1) % 4;
            int  cy = (c - 1) / 4;
            logic en = (x + cx <= 159) && (y + cy <= 119);
            checks++;
            if (en_r1[c] !== en || en_r3[c] !== en) begin
                errors++;
                $display("FAIL rd_en cycle %0d: got %b/%b want %b", c, en_r1[c], en_r3[c], en);
            end
            if (en) begin
                checks++;
                if (x_r1[c] !== 8'(x + cx) || y_r1[c] !== 7'(y + cy) ||
                    x_r3[c] !== 8'(x + cx) || y_r3[c] !== 7'(y + cy)) begin
                    errors++;
                    $display("FAIL rd_xy cycle %0d: got (%0d,%0d)/(%0d,%0d) want (%0d,%0d)",
                             c, x_r1[c], y_r1[c], x_r3[c], y_r3[c], x + cx, y + cy);
                end
            end
        end
        checks++;
        if (done_c1 != N + 2 || done_c3 != N + 4) begin
            errors++;
            $display("FAIL done_cycle: got %0d/%0d want %0d/%0d", done_c1, done_c3, N + 2, N + 4);
        end
        checks++;
        if (hit_d1 !== (exp_cnt != 0) || cnt_d1 !== 7'(exp_cnt)) begin
            errors++;
            $display("FAIL result_lat1: got hit=%b cnt=%0d want hit=%b cnt=%0d",
                     hit_d1, cnt_d1, exp_cnt != 0, exp_cnt);
        end
        checks++;
        if (hit_d3 !== (exp_cnt != 0) || cnt_d3 !== 7'(exp_cnt)) begin
            errors++;
            $display("FAIL result_lat3: got hit=%b cnt=%0d want hit=%b cnt=%0d",
                     hit_d3, cnt_d3, exp_cnt != 0, exp_cnt);
        end
        if (!hold) begin
            checks++;
            if (done_n1 != 1 || done_n3 != 1) begin
                errors++;
                $display("FAIL done_pulse: got %0d/%0d pulses want 1", done_n1, done_n3);
            end
            checks++;
            if (hit_count1 !== 7'(exp_cnt) || hit_count3 !== 7'(exp_cnt) || busy1 !== 1'b0) begin
                errors++;
                $display("FAIL hold_idle: got cnt=%0d/%0d busy=%b want cnt=%0d busy=0",
                         hit_count1, hit_count3, busy1, exp_cnt);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; x_in = '0; y_in = '0; bg_colour = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({rd_en1, rd_x1, rd_y1, busy1, done1, hit1, hit_count1} !== '0 ||
            {rd_en3, rd_x3, rd_y3, busy3, done3, hit3, hit_count3} !== '0) begin
            errors++;
            $display("FAIL reset_state: got en=%b x=%0d y=%0d busy=%b done=%b hit=%b cnt=%0d want all 0",
                     rd_en1, rd_x1, rd_y1, busy1, done1, hit1, hit_count1);
        end
        #1 reset = 1'b0;
    endtask

    task automatic test_black();
        clear_fb();
        run_scan(78, 105, 0, 1'b0);
    endtask

    task automatic test_single();
        clear_fb();
        fb[80][107] = 3'b100;
        run_scan(78, 105, 0, 1'b0);
    endtask

    task automatic test_corner();
        int n = 0;
        fill_box(158, 118, 5);
        run_scan(158, 118, 0, 1'b0);
        for (int c = 1; c <= N; c++) if (en_r1[c] === 1'b1) n++;
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL corner_reads: got %0d want 4", n);
        end
    endtask

    task automatic test_back_to_back();
        clear_fb();
        fb[21][31] = 3'd6;
        run_scan(20, 30, 0, 1'b1);
        checks++;
        if (busy_r1[18] !== 1'b1 || busy_r1[19] !== 1'b0 || busy_r1[20] !== 1'b1 ||
            x_r1[20] !== 8'd10) begin
            errors++;
            $display("FAIL back_to_back: got busy18=%b busy19=%b busy20=%b x20=%0d want 1 0 1 10",
                     busy_r1[18], busy_r1[19], busy_r1[20], x_r1[20]);
        end
        pulse_reset();
    endtask

    task automatic test_reset_mid();
        int dn = 0;
        clear_fb();
        fb[40][50] = 3'd5;
        @(posedge clk); #1;
        start = 1'b1; x_in = 8'd40; y_in = 7'd50; bg_colour = 3'd0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        checks++;
        if (hit1 !== 1'b1 || hit3 !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_hit: got %b/%b want 1", hit1, hit3);
        end
        @(negedge clk);
        checks++;
        if ({busy1, rd_en1, hit1, hit_count1} !== '0 || {busy3, rd_en3, hit3, hit_count3} !== '0) begin
            errors++;
            $display("FAIL abort: got busy=%b en=%b hit=%b cnt=%0d want all 0",
                     busy1, rd_en1, hit1, hit_count1);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done1 !== 1'b0 || done3 !== 1'b0 || busy1 !== 1'b0) dn++;
        end
        checks++;
        if (dn != 0) begin
            errors++;
            $display("FAIL no_done_after_reset: got %0d active cycles want 0", dn);
        end
    endtask

    task automatic test_full();
        clear_fb();
        fill_box(60, 60, 3);
        run_scan(60, 60, 0, 1'b0);
        run_scan(100, 20, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 160; i++)
            for (int j = 0; j < 120; j++)
                fb[i][j] = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom);
        for (int k = 0; k < 8; k++) begin
            int x, y;
            x = (k % 2 == 0) ? int'($urandom_range(150, 159)) : int'($urandom_range(0, 159));
            y = (k % 3 == 0) ? int'($urandom_range(112, 119)) : int'($urandom_range(0, 119));
            run_scan(x, y, int'($urandom_range(0, 7)), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_black();
        test_single();
        test_corner();
        test_back_to_back();
        test_reset_mid();
        test_full();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
